// File: rtl/apb_multi_slave_master_if.sv
// Command-side and APB4-side signal bundle for apb_multi_slave_master.
// The master modport is the DUT view; the slave modport is the requester/slave-side view.
interface apb_multi_slave_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                      transfer;
    logic                      ready;
    logic                      write_en;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;
    logic [DATA_W/8-1:0]       strb;
    logic [2:0]                prot;
    logic                      pnse;
    logic                      done;
    logic [DATA_W-1:0]         rdata;
    logic                      error;

    logic [NUM_SLV-1:0]        PSELx;
    logic                      PENABLE;
    logic [ADDR_W-1:0]         PADDR;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W/8-1:0]       PSTRB;
    logic [2:0]                PPROT;
    logic                      PNSE;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    modport master (
        input  transfer, write_en, waddr, wdata, strb, prot, pnse,
        input  PRDATA, PREADY, PSLVERR,
        output ready, done, rdata, error,
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE
    );

    modport slave (
        output transfer, write_en, waddr, wdata, strb, prot, pnse,
        output PRDATA, PREADY, PSLVERR,
        input  ready, done, rdata, error,
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE
    );
endinterface

// File: rtl/apb_multi_slave_master.sv
// APB4 master decoding one local request onto NUM_SLV slave windows of 2**SLV_AW bytes.
// Optional ACCESS-phase wait timeout enabled by defining APB_TIMEOUT_EN.
module apb_multi_slave_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_AW  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_multi_slave_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = ADDR_W - SLV_AW;
    localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    if (TIMEOUT < 1 || NUM_SLV < 1 || (DATA_W % 8) != 0) begin : g_param_check
        $error("apb_multi_slave_master: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DECERR} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [2:0]          pprot_q, pprot_d;
    logic                pnse_q, pnse_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                error_q, error_d;

    logic [IDX_W-1:0]    req_idx;
    logic                in_range;
    logic [SEL_W-1:0]    req_sel;
    logic [NUM_SLV-1:0]  req_onehot;
    logic                sel_pready;
    logic                sel_pslverr;
    logic [DATA_W-1:0]   sel_prdata;
    logic                ready;
    logic                accept;
    logic                tmo_hit;

    assign req_idx  = bus.waddr[ADDR_W-1:SLV_AW];
    assign in_range = {1'b0, req_idx} < (IDX_W+1)'(NUM_SLV);
    assign req_sel  = req_idx[SEL_W-1:0];

    // Only the currently selected slave's response is ever looked at.
    always_comb begin
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        sel_prdata  = '0;
        req_onehot  = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_pready  = bus.PREADY[k];
                sel_pslverr = bus.PSLVERR[k];
                sel_prdata  = bus.PRDATA[k*DATA_W +: DATA_W];
            end
            req_onehot[k] = (req_sel == SEL_W'(k));
        end
    end

    assign ready  = (state_q == S_IDLE) || ((state_q == S_ACCESS) && sel_pready);
    assign accept = bus.transfer && ready;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_q, wait_d;

    assign tmo_hit = (wait_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        wait_d = wait_q;
        if (state_q == S_SETUP)
            wait_d = '0;
        else if ((state_q == S_ACCESS) && !sel_pready)
            wait_d = wait_q + CNT_W'(1);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) wait_q <= '0;
        else          wait_q <= wait_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        pnse_d    = pnse_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        error_d   = error_q;

        case (state_q)
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (sel_pready) begin
                    done_d    = 1'b1;
                    error_d   = sel_pslverr;
                    if (!pwrite_q) rdata_d = sel_pslverr ? '0 : sel_prdata;
                    state_d   = S_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else if (tmo_hit) begin
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    rdata_d   = '0;
                    state_d   = S_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end
            end
            S_DECERR: begin
                done_d  = 1'b1;
                error_d = 1'b1;
                rdata_d = '0;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // A new request overrides the completion's return-to-idle.
        if (accept) begin
            penable_d = 1'b0;
            if (in_range) begin
                state_d  = S_SETUP;
                sel_d    = req_sel;
                psel_d   = req_onehot;
                paddr_d  = bus.waddr;
                pwrite_d = bus.write_en;
                pprot_d  = bus.prot;
                pnse_d   = bus.pnse;
                pstrb_d  = bus.write_en ? bus.strb : '0;
                if (bus.write_en) pwdata_d = bus.wdata;
            end else begin
                state_d = S_DECERR;
                psel_d  = '0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            pnse_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            pnse_q    <= pnse_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    assign bus.ready   = ready;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.error   = error_q;
    assign bus.PSELx   = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PPROT   = pprot_q;
    assign bus.PNSE    = pnse_q;
endmodule
